// File: rtl/data_sram_slave.sv
// 128 x 32 single-port SRAM slave with a post-reset zeroing sweep, combinational
// read port, sticky early-access flag and saturating access counters.
module data_sram_slave (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CEN,
  input  logic        WEN,
  input  logic        OEN,
  input  logic [6:0]  A,
  input  logic [31:0] D,
  output logic [31:0] Q,
  output logic        ready,
  output logic        init_err,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [6:0]  LAST_ADDR = 7'd127;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  state_t      state, state_nxt;
  logic [6:0]  sweep_ptr, sweep_ptr_nxt;
  logic [31:0] mem [128];
  logic        run_wr, run_rd, init_acc;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_nxt     = state;
    sweep_ptr_nxt = sweep_ptr;
    if (state == INIT) begin
      sweep_ptr_nxt = sweep_ptr + 7'd1;
      if (sweep_ptr == LAST_ADDR) state_nxt = RUN;
    end
  end

  assign run_wr   = (state == RUN)  && !CEN && !WEN;
  assign run_rd   = (state == RUN)  && !CEN &&  WEN && !OEN;
  assign init_acc = (state == INIT) && !CEN;
  assign ready    = (state == RUN);

  // Zero-latency read; the array is only read here, so write data never
  // reaches Q in the cycle it is presented.
  assign Q = run_rd ? mem[A] : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_ptr <= 7'd0;
      init_err  <= 1'b0;
      rd_cnt    <= 16'd0;
      wr_cnt    <= 16'd0;
    end else begin
      state     <= state_nxt;
      sweep_ptr <= sweep_ptr_nxt;
      if (init_acc) init_err <= 1'b1;
      if (run_rd && rd_cnt != CNT_MAX) rd_cnt <= rd_cnt + 16'd1;
      if (run_wr && wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  // NOTE: the array has no reset branch; the post-release sweep zeroes it, and
  // gating on rst_n drops any write landing while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT)  mem[sweep_ptr] <= 32'h0;
      else if (run_wr)    mem[A]         <= D;
    end
  end

endmodule

// File: tb/tb_data_sram_slave.sv
// Self-checking bench for data_sram_slave: a reference memory/counter model
// feeds a queue of expected Q values that is drained as the DUT drives Q.
module tb_data_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n, CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] D;
  logic [31:0] Q;
  logic        ready, init_err;
  logic [15:0] rd_cnt, wr_cnt;

  data_sram_slave dut (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN),
    .A(A), .D(D), .Q(Q), .ready(ready), .init_err(init_err),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_model [128];
  logic [15:0] rd_exp, wr_exp;
  logic        err_exp;
  logic [31:0] q_queue [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs();
    check("rd_cnt", {16'h0, rd_cnt}, {16'h0, rd_exp});
    check("wr_cnt", {16'h0, wr_cnt}, {16'h0, wr_exp});
    check("init_err", {31'h0, init_err}, {31'h0, err_exp});
  endtask

  // Hold reset for two edges, check reset values, release just after an edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; A = '0; D = '0;
    rd_exp = '0; wr_exp = '0; err_exp = 1'b0;
    tick();
    tick();
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_q", Q, 32'h0);
    check_regs();
    rst_n = 1'b1;
  endtask

  // Walk the 128 sweep edges; optionally inject one write at edge err_edge.
  task automatic run_sweep(input int err_edge);
    for (int k = 1; k <= 128; k++) begin
      if (k == err_edge) begin
        CEN = 1'b0; WEN = 1'b0; OEN = 1'b0; A = 7'h03; D = 32'h12345678;
      end else begin
        CEN = 1'b1; WEN = $urandom_range(0, 1); OEN = $urandom_range(0, 1);
        A = 7'($urandom); D = $urandom;
      end
      @(negedge clk);
      check("init_q", Q, 32'h0);
      tick();
      if (k == err_edge) err_exp = 1'b1;
      check("sweep_ready", {31'h0, ready}, {31'h0, (k == 128)});
      check("sweep_init_err", {31'h0, init_err}, {31'h0, err_exp});
    end
    for (int i = 0; i < 128; i++) mem_model[i] = 32'h0;
    CEN = 1'b1;
  endtask

  // One RUN-mode cycle: push expected Q, compare it mid-cycle, update model.
  task automatic access(input logic cen, input logic wen, input logic oen,
                        input logic [6:0] a, input logic [31:0] d);
    logic [31:0] exp_q;
    CEN = cen; WEN = wen; OEN = oen; A = a; D = d;
    q_queue.push_back((!cen && wen && !oen) ? mem_model[a] : 32'h0);
    @(negedge clk);
    if (q_queue.size() == 0) begin
      check("sb_empty", 32'h1, 32'h0);
    end else begin
      exp_q = q_queue.pop_front();
      check("q", Q, exp_q);
    end
    tick();
    if (!cen && !wen) begin
      mem_model[a] = d;
      if (wr_exp != 16'hFFFF) wr_exp++;
    end else if (!cen && !oen) begin
      if (rd_exp != 16'hFFFF) rd_exp++;
    end
    check_regs();
  endtask

  initial begin
    // Power-up sweep with the bus idle, then every address reads zero.
    apply_reset();
    run_sweep(0);
    for (int i = 0; i < 128; i++) access(1'b0, 1'b1, 1'b0, 7'(i), 32'h0);

    // Write then read back; write cycle itself must show Q=0.
    access(1'b0, 1'b0, 1'b0, 7'h05, 32'hDEADBEEF);
    access(1'b0, 1'b1, 1'b0, 7'h05, 32'h0);
    // Read with OEN=1 (no-op), then WEN=0 (a write, Q stays 0).
    access(1'b0, 1'b1, 1'b1, 7'h05, 32'h0);
    access(1'b0, 1'b0, 1'b0, 7'h05, 32'hCAFEF00D);
    access(1'b0, 1'b1, 1'b0, 7'h05, 32'h0);
    // Chip disabled with other strobes active.
    access(1'b1, 1'b0, 1'b0, 7'h05, 32'h11111111);
    access(1'b1, 1'b1, 1'b0, 7'h05, 32'h0);
    access(1'b0, 1'b1, 1'b0, 7'h05, 32'h0);

    // Mixed random traffic.
    for (int i = 0; i < 200; i++)
      access(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
             7'($urandom), $urandom);

    // Drive wr_cnt into saturation and confirm it holds.
    for (int i = 0; i < 65540; i++)
      access(1'b0, 1'b0, 1'($urandom), 7'($urandom), $urandom);
    check("wr_sat", {16'h0, wr_cnt}, 32'h0000FFFF);
    access(1'b0, 1'b0, 1'b0, 7'h09, 32'hA5A5A5A5);
    access(1'b0, 1'b1, 1'b0, 7'h09, 32'h0);

    // Asynchronous reset mid-cycle while a read of A=9 is presented.
    CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = 7'h09;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_ready", {31'h0, ready}, 32'h0);
    check("async_rd_cnt", {16'h0, rd_cnt}, 32'h0);
    check("async_wr_cnt", {16'h0, wr_cnt}, 32'h0);
    check("async_q", Q, 32'h0);

    // Fresh sweep with an illegal write at edge 10; memory must be zero after.
    apply_reset();
    run_sweep(10);
    access(1'b0, 1'b1, 1'b0, 7'h09, 32'h0);
    access(1'b0, 1'b1, 1'b0, 7'h03, 32'h0);
    access(1'b0, 1'b0, 1'b0, 7'h03, 32'h76543210);
    access(1'b0, 1'b1, 1'b0, 7'h03, 32'h0);
    check("init_err_sticky", {31'h0, init_err}, 32'h1);
    check("sb_drained", q_queue.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_slave.md
DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the port list below (clock and reset first).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 CEN  input  1  chip enable, active low; 0 = access this cycle.
REQ-005 WEN  input  1  write enable, active low; 0 = write, 1 = read (qualified by CEN).
REQ-006 OEN  input  1  output enable, active low; 0 = drive read data on Q.
REQ-007 A  input  7  word address, 128 words.
REQ-008 D  input  32  write data.
REQ-009 Q  output  32  read data.
REQ-010 ready  output  1  1 = init sweep done, accesses honoured.
REQ-011 init_err  output  1  sticky; 1 = an access (CEN=0) arrived while ready=0.
REQ-012 rd_cnt  output  16  count of honoured reads, saturating.
REQ-013 wr_cnt  output  16  count of honoured writes, saturating.

Function
REQ-014 Storage SHALL be 128 x 32-bit words, indexed by A.
REQ-015 State machine SHALL have two states: INIT and RUN.
REQ-016 INIT: each rising edge writes 0 to mem[sweep_ptr] and increments the 7-bit sweep_ptr, starting from 0.
REQ-017 INIT -> RUN on the edge that writes address 127 (exactly 128 edges after reset release); ready SHALL be 1 from the following cycle.
REQ-018 RUN SHALL persist until rst_n is asserted; there is no other transition.
REQ-019 Write: in RUN, CEN=0 and WEN=0 at a rising edge -> mem[A] <= D; OEN ignored; wr_cnt increments.
REQ-020 Read: in RUN, with CEN=0, WEN=1, OEN=0 -> Q = mem[A] combinationally, same cycle (zero latency, for the single-cycle core); rd_cnt increments at the rising edge.
REQ-021 In every other case Q SHALL be 32'h0: INIT, CEN=1, WEN=0, or OEN=1.
REQ-022 CEN=0, WEN=1, OEN=1 SHALL be a no-op: no count, Q=0.
REQ-023 Write-then-read on the same address SHALL return the new data from the cycle after the write edge; Q SHALL never show D combinationally (no write-through).
REQ-024 Accesses with CEN=0 in INIT SHALL:
  - be ignored (no memory change, no count);
  - set init_err at that edge.
REQ-025 init_err SHALL clear only on reset.
REQ-026 rd_cnt and wr_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-027 Counters SHALL increment at most once per edge; a read and a write are mutually exclusive by WEN.
REQ-028 Sweep writes SHALL use sweep_ptr only; A and D SHALL be don't-care in INIT.

Reset
REQ-029 Reset values: state=INIT, sweep_ptr=0, ready=0, init_err=0, rd_cnt=0, wr_cnt=0.
REQ-030 Q SHALL be 0 throughout reset.
REQ-031 Memory contents SHALL NOT be cleared by rst_n itself; they are zeroed by the INIT sweep after release.
REQ-032 Reset asserted mid-sweep or mid-RUN SHALL take effect immediately (asynchronously) and restart the full 128-cycle sweep after release.
REQ-033 A write in progress at the same edge that reset asserts SHALL be discarded.

Verification
REQ-034 Release reset, hold CEN=1 -> ready=0 for 128 edges, ready=1 thereafter; a read of every address returns 32'h0.
REQ-035 RUN: write A=7'h05, D=32'hDEADBEEF, then read A=5 with OEN=0 -> Q=32'hDEADBEEF the next cycle; wr_cnt=1, rd_cnt=1.
REQ-036 Access during INIT: CEN=0, WEN=0, A=3, D=32'h12345678 at edge 10 -> init_err=1 from edge 10 onward; after ready=1, a read of A=3 returns 32'h0.
REQ-037 Read A=5 with OEN=1, then with WEN=0 -> Q=0 in both cycles; rd_cnt unchanged.
REQ-038 Preload wr_cnt near saturation (65540 back-to-back writes) -> wr_cnt=16'hFFFF and holds.
REQ-039 Assert rst_n low mid-RUN after writing A=9 -> ready=0 and counters=0 immediately; after the new sweep, a read of A=9 returns 32'h0.
